// File: rtl/pow_5_requester.sv
// Initiator for the pow_5 unit's run/ready handshake: takes one operand from a
// valid/ready source, pulses run, waits (with timeout) for ready, then holds the response.
module pow_5_requester #(
    parameter int WIDTH   = 18,
    parameter int TIMEOUT = 31   // must be >= 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_n,
    output logic             req_ready,
    output logic             run,
    output logic [WIDTH-1:0] n,
    input  logic             ready,
    input  logic [WIDTH-1:0] result,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_error,
    input  logic             rsp_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] n_nx;
    logic [WIDTH-1:0] rsp_result_nx;
    logic             rsp_error_nx;
    logic             req_ready_nx;

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        n_nx          = n;
        rsp_result_nx = rsp_result;
        rsp_error_nx  = rsp_error;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    n_nx     = req_n;
                    cnt_nx   = '0;
                    state_nx = ISSUE;
                end
            end
            // The unit has not seen run yet, so any ready here cannot be ours.
            ISSUE: begin
                state_nx = WAIT;
            end
            WAIT: begin
                cnt_nx = cnt + CNT_W'(1);
                if (ready) begin
                    rsp_result_nx = result;
                    rsp_error_nx  = 1'b0;
                    state_nx      = RESP;
                end else if (cnt_nx == TIMEOUT_CNT) begin
                    rsp_result_nx = '0;
                    rsp_error_nx  = 1'b1;
                    state_nx      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Registered so that req_ready stays low for the whole reset assertion.
        req_ready_nx = (state_nx == IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            n          <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            req_ready  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            n          <= n_nx;
            rsp_result <= rsp_result_nx;
            rsp_error  <= rsp_error_nx;
            req_ready  <= req_ready_nx;
        end
    end

    assign run       = (state == ISSUE);
    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_pow_5_requester.sv
// Directed and randomized bench for pow_5_requester; the pow_5 unit is played by the
// stimulus sequence itself, with expected timing and results derived arithmetically.
module tb_pow_5_requester;

    localparam int WIDTH   = 18;
    localparam int TIMEOUT = 31;

    logic             clock;
    logic             reset_n;
    logic             req_valid;
    logic [WIDTH-1:0] req_n;
    logic             req_ready;
    logic             run;
    logic [WIDTH-1:0] n;
    logic             ready;
    logic [WIDTH-1:0] result;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_error;
    logic             rsp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    pow_5_requester #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_n      (req_n),
        .req_ready  (req_ready),
        .run        (run),
        .n          (n),
        .ready      (ready),
        .result     (result),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .rsp_ready  (rsp_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [WIDTH-1:0] pow5(input logic [WIDTH-1:0] x);
        logic [63:0] acc;
        acc = 64'd1;
        for (int i = 0; i < 5; i++) acc = acc * {46'd0, x};
        return acc[WIDTH-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    // lat: edges after the run-sampling edge until ready; lat < 1 means never answer.
    task automatic transact(input logic [WIDTH-1:0] opn, input int lat, input bit issue_ready);
        int               exp_edge;
        logic [WIDTH-1:0] exp_res;
        logic             exp_err;
        bit               done;
        if (lat >= 1 && lat <= TIMEOUT) begin
            exp_edge = lat + 1;
            exp_res  = pow5(opn);
            exp_err  = 1'b0;
        end else begin
            exp_edge = TIMEOUT + 1;
            exp_res  = '0;
            exp_err  = 1'b1;
        end
        check("accept_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_n     = opn;
        cycle();
        req_valid = 1'b0;
        req_n     = WIDTH'($urandom);
        check("run_pulse", run, 1);
        check("n_latched", n, opn);
        check("busy_req_ready", req_ready, 0);
        done = 1'b0;
        for (int e = 1; e <= TIMEOUT + 4 && !done; e++) begin
            ready  = (e == lat + 1) || (issue_ready && e == 1);
            result = (e == lat + 1) ? pow5(opn) : WIDTH'($urandom);
            cycle();
            ready = 1'b0;
            if (e < exp_edge) begin
                check("no_rsp_yet", rsp_valid, 0);
                check("run_single", run, 0);
            end else begin
                check("rsp_valid", rsp_valid, 1);
                check("rsp_result", rsp_result, exp_res);
                check("rsp_error", rsp_error, exp_err);
                check("n_held", n, opn);
                done = 1'b1;
            end
        end
        check("rsp_arrived", done, 1);
    endtask

    // Holds off the response for 'hold' cycles while offering a competing request.
    task automatic consume(input int hold);
        logic [WIDTH-1:0] held_res;
        logic             held_err;
        held_res  = rsp_result;
        held_err  = rsp_error;
        rsp_ready = 1'b0;
        req_valid = (hold > 0);
        req_n     = WIDTH'($urandom);
        for (int i = 0; i < hold; i++) begin
            cycle();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_result", rsp_result, held_res);
            check("bp_rsp_error", rsp_error, held_err);
            check("bp_req_ready", req_ready, 0);
            check("bp_no_run", run, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        check("consumed_rsp_valid", rsp_valid, 0);
        check("consumed_req_ready", req_ready, 1);
        check("consumed_run", run, 0);
    endtask

    task automatic idle_stale_ready();
        ready  = 1'b1;
        result = WIDTH'($urandom);
        cycle();
        ready = 1'b0;
        check("stale_rsp_valid", rsp_valid, 0);
        check("stale_req_ready", req_ready, 1);
        check("stale_run", run, 0);
        cycle();
        check("stale_rsp_valid_after", rsp_valid, 0);
    endtask

    initial begin
        int lat;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_n     = '0;
        ready     = 1'b0;
        result    = '0;
        rsp_ready = 1'b0;

        #1;
        check("rst_run", run, 0);
        check("rst_n", n, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_req_ready", req_ready, 0);
        @(negedge clock);
        @(negedge clock);
        check("rst_hold_req_ready", req_ready, 0);
        reset_n = 1'b1;
        cycle();
        check("post_rst_req_ready", req_ready, 1);

        idle_stale_ready();

        transact(18'd3, 5, 1'b0);
        consume(0);
        transact(18'd7, 5, 1'b0);
        consume(2);
        transact(18'd13, 5, 1'b0);
        consume(0);
        transact(18'd12, 5, 1'b0);
        consume(0);

        transact(WIDTH'($urandom), -1, 1'b0);
        consume(1);
        transact(18'd5, TIMEOUT, 1'b0);
        consume(0);
        transact(18'd9, 5, 1'b1);
        consume(0);
        transact(18'd21, 5, 1'b0);
        consume(5);
        transact(18'h3FFFF, 1, 1'b0);
        consume(0);

        for (int t = 0; t < 20; t++) begin
            lat = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, TIMEOUT));
            transact(WIDTH'($urandom), lat, (lat > 1) && $urandom_range(0, 1) == 1);
            consume(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle_stale_ready();
        end

        // Reset while waiting for the unit: a pending result from before must be cleared.
        transact(18'd3, 5, 1'b0);
        consume(0);
        check("pre_rst_result", rsp_result, 243);
        check("mr_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_n     = 18'd11;
        cycle();
        req_valid = 1'b0;
        check("mr_run", run, 1);
        cycle();
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_rst_run", run, 0);
        check("mr_rst_n", n, 0);
        check("mr_rst_rsp_valid", rsp_valid, 0);
        check("mr_rst_rsp_result", rsp_result, 0);
        check("mr_rst_rsp_error", rsp_error, 0);
        check("mr_rst_req_ready", req_ready, 0);
        @(negedge clock);
        cycle();
        reset_n = 1'b1;
        ready   = 1'b1;
        result  = pow5(18'd11);
        cycle();
        ready = 1'b0;
        check("mr_late_rsp_valid", rsp_valid, 0);
        check("mr_late_run", run, 0);
        check("mr_post_req_ready", req_ready, 1);
        cycle();
        check("mr_late_rsp_valid2", rsp_valid, 0);
        transact(18'd2, 5, 1'b0);
        check("mr_result_32", rsp_result, 32);
        consume(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
